// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, bit timing and the parity helper
// used by both the transmitter and the receiver's error check.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_e;

   localparam int unsigned TICKS_PER_BIT = 16;

   // Data is zero-extended by the caller; extra zero bits do not change the XOR.
   function automatic logic calc_parity(input logic [63:0] data, input logic par_typ);
      return (^data) ^ par_typ;
   endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, one parity bit, SB_TICK-tick stop,
// all timed from the shared 16x oversampling tick enable.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned PAR_TYP   = 0,
   parameter int unsigned SB_TICK   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tick,
   input  logic                 tx_valid,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam int unsigned BitW = $clog2(DATA_BITS) + 1;

   localparam logic [5:0]      BitEnd  = 6'(TICKS_PER_BIT - 1);
   localparam logic [5:0]      StopEnd = 6'(SB_TICK - 1);
   localparam logic [BitW-1:0] LastBit = BitW'(DATA_BITS - 1);

   uart_tx_state_e       state_q, state_d;
   logic [5:0]           tick_cnt_q, tick_cnt_d;
   logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 parity_q, parity_d;
   logic                 tx_q, tx_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         parity_q   <= 1'b0;
         tx_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         parity_q   <= parity_d;
         tx_q       <= tx_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      parity_d   = parity_q;
      tx_done    = 1'b0;

      unique case (state_q)
         IDLE: begin
            // A tick coinciding with the accept is deliberately not counted.
            if (tx_valid) begin
               state_d    = START;
               tick_cnt_d = '0;
               bit_cnt_d  = '0;
               shift_d    = tx_data;
               parity_d   = calc_parity(64'(tx_data), 1'(PAR_TYP));
            end
         end
         START: begin
            if (tick) begin
               if (tick_cnt_q == BitEnd) begin
                  tick_cnt_d = '0;
                  state_d    = DATA;
               end else begin
                  tick_cnt_d = tick_cnt_q + 6'd1;
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (tick_cnt_q == BitEnd) begin
                  tick_cnt_d = '0;
                  shift_d    = shift_q >> 1;
                  if (bit_cnt_q == LastBit) begin
                     state_d = PARITY;
                  end else begin
                     bit_cnt_d = bit_cnt_q + BitW'(1);
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + 6'd1;
               end
            end
         end
         PARITY: begin
            if (tick) begin
               if (tick_cnt_q == BitEnd) begin
                  tick_cnt_d = '0;
                  state_d    = STOP;
               end else begin
                  tick_cnt_d = tick_cnt_q + 6'd1;
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (tick_cnt_q == StopEnd) begin
                  tick_cnt_d = '0;
                  tx_done    = 1'b1;
                  state_d    = IDLE;
               end else begin
                  tick_cnt_d = tick_cnt_q + 6'd1;
               end
            end
         end
         default: begin
            state_d    = IDLE;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
         end
      endcase
   end

   // The line value is decoded from the next state so tx leaves a flop, glitch-free.
   always_comb begin
      tx_d = 1'b1;
      unique case (state_d)
         IDLE:    tx_d = 1'b1;
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         PARITY:  tx_d = parity_d;
         STOP:    tx_d = 1'b1;
         default: tx_d = 1'b1;
      endcase
   end

   assign tx       = tx_q;
   assign tx_ready = (state_q == IDLE);
   assign tx_busy  = !tx_ready;

endmodule

// File: tb/tb_uart_tx.sv
// Directed and random bench for uart_tx: a line monitor decodes every frame and compares it with
// the bytes queued by the stimulus when they were accepted.
module tb_uart_tx;

   localparam int FRAME = (1 + 8 + 1) * 16 + 16;

   logic       clk;
   logic       rst_n;
   logic       tick;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       tx;
   logic       tx_busy;
   logic       tx_done;

   logic       vo;
   logic [7:0] do_data;
   logic       tx_ready_o;
   logic       tx_o;
   logic       tx_busy_o;
   logic       tx_done_o;

   int checks = 0;
   int errors = 0;
   int tick_period = 1;
   int tick_cnt = 0;

   logic [7:0] q[$];
   int   cyc = 0;
   int   done_cyc = 0;
   int   acc_cyc = 0;
   int   frames_done = 0;
   bit   mon_active = 0;
   int   mon_ticks = 0;
   int   frame_cyc = 0;
   int   first_tick_cyc = 0;
   bit   mon_bad = 0;
   logic bits [0:10];

   uart_tx #(.DATA_BITS(8), .PAR_TYP(0), .SB_TICK(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick),
      .tx_valid (tx_valid),
      .tx_data  (tx_data),
      .tx_ready (tx_ready),
      .tx       (tx),
      .tx_busy  (tx_busy),
      .tx_done  (tx_done)
   );

   uart_tx #(.DATA_BITS(8), .PAR_TYP(1), .SB_TICK(16)) dut_odd (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick),
      .tx_valid (vo),
      .tx_data  (do_data),
      .tx_ready (tx_ready_o),
      .tx       (tx_o),
      .tx_busy  (tx_busy_o),
      .tx_done  (tx_done_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      tick = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         tick_cnt++;
         if (tick_cnt >= tick_period) begin
            tick = 1'b1;
            tick_cnt = 0;
         end else begin
            tick = 1'b0;
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Line monitor: counts ticks from the first low cycle and samples every tick of every bit.
   initial begin : monitor
      logic [7:0] d;
      logic [7:0] rx;
      int         idx;
      bit         at_end;
      forever begin
         @(negedge clk);
         cyc++;
         at_end = 0;
         if (!rst_n) begin
            mon_active = 0;
         end else begin
            if (!mon_active && tx === 1'b0) begin
               mon_active = 1;
               mon_ticks  = 0;
               frame_cyc  = 0;
               mon_bad    = 0;
            end
            if (mon_active) begin
               frame_cyc++;
               if (tick) begin
                  mon_ticks++;
                  if (mon_ticks == 1) first_tick_cyc = cyc;
                  idx = (mon_ticks - 1) / 16;
                  if ((mon_ticks - 1) % 16 == 0) bits[idx] = tx;
                  else if (bits[idx] !== tx) mon_bad = 1;
                  if (mon_ticks == FRAME) begin
                     at_end = 1;
                     chk("done_pulse", tx_done, 1);
                     chk("bit_stable", mon_bad, 0);
                     chk("start_bit", bits[0], 0);
                     chk("stop_bit", bits[10], 1);
                     chk("scoreboard_nonempty", q.size() != 0, 1);
                     if (q.size() != 0) begin
                        d = q.pop_front();
                        for (int i = 0; i < 8; i++) rx[i] = bits[i+1];
                        chk("data", rx, d);
                        chk("parity", bits[9], ^d);
                     end
                     chk("bit_time", cyc - first_tick_cyc, 175 * tick_period);
                     if (tick_period == 1) chk("frame_len", frame_cyc, FRAME);
                     done_cyc = cyc;
                     frames_done++;
                     mon_active = 0;
                  end
               end
            end
         end
         if (!at_end) chk("spurious_done", tx_done, 0);
      end
   end

   task automatic send(input logic [7:0] d);
      bit ok;
      ok = 0;
      tx_valid = 1'b1;
      tx_data  = d;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (tx_ready) begin
            ok = 1;
            break;
         end
      end
      @(posedge clk);
      if (ok) begin
         acc_cyc = cyc;
         q.push_back(d);
      end
      #1;
      tx_valid = 1'b0;
      tx_data  = ~d;
      chk("accept_timeout", ok, 1);
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         if (!mon_active && tx_ready && q.size() == 0) begin
            ok = 1;
            break;
         end
      end
      #1;
      chk("idle_timeout", ok, 1);
   endtask

   task automatic send_odd(input logic [7:0] d, input logic exp_par);
      @(posedge clk);
      #1;
      vo = 1'b1;
      do_data = d;
      @(negedge clk);
      chk("odd_ready", tx_ready_o, 1);
      @(posedge clk);
      #1;
      vo = 1'b0;
      repeat (151) @(posedge clk);
      @(negedge clk);
      chk("odd_parity", tx_o, exp_par);
      repeat (30) @(posedge clk);
      #1;
      chk("odd_idle", tx_ready_o, 1);
   endtask

   initial begin : stim
      int fd;
      rst_n    = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      vo       = 1'b0;
      do_data  = 8'h00;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_tx", tx, 1);
      chk("rst_busy", tx_busy, 0);
      chk("rst_done", tx_done, 0);
      chk("rst_ready", tx_ready, 1);
      chk("rst_tx_odd", tx_o, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Even parity, tick every clock.
      tick_period = 1;
      send(8'hA5);
      @(negedge clk);
      chk("start_low", tx, 0);
      chk("busy_in_frame", tx_busy, 1);
      wait_idle();

      // Odd parity instance.
      send_odd(8'h00, 1'b1);
      send_odd(8'h01, 1'b0);

      // Slow tick with a byte offered mid-frame.
      tick_period = 4;
      send(8'h12);
      repeat (200) @(posedge clk);
      #1;
      chk("slow_ready_low", tx_ready, 0);
      chk("slow_busy", tx_busy, 1);
      fd = frames_done;
      send(8'h3C);
      chk("slow_after_done", frames_done, fd + 1);
      chk("slow_accept_gap", acc_cyc - done_cyc, 1);
      wait_idle();

      // Back-to-back with tx_valid held.
      tick_period = 1;
      repeat (4) @(posedge clk);
      #1;
      send(8'h55);
      send(8'hAA);
      chk("b2b_gap", acc_cyc - done_cyc, 1);
      wait_idle();

      // Reset during data bit 3.
      fd = frames_done;
      send(8'hF0);
      repeat (70) @(posedge clk);
      chk("tx_pre_rst", tx, 0);
      chk("busy_pre_rst", tx_busy, 1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_tx", tx, 1);
      chk("rst_mid_busy", tx_busy, 0);
      chk("rst_mid_done", tx_done, 0);
      q.delete();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      send(8'h81);
      wait_idle();
      chk("rst_frames", frames_done, fd + 1);

      // Random bytes with random gaps.
      for (int n = 0; n < 40; n++) begin
         repeat ($urandom_range(0, 20)) @(posedge clk);
         #1;
         send(8'($urandom));
      end
      wait_idle();
      chk("scoreboard_drained", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
